tinker_muldiv: RTL and testbench
================================

TINKER_MULDIV -- requirements
Module: tinker_muldiv

Interface
REQ-001 Parameter WIDTH, default 64, operand/result width (≥4).
REQ-002 Parameter TAG_W, default 5, destination-register tag width.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset, with ports named as follows.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous active-high reset.
REQ-006 start_valid  in  1  request present.
REQ-007 start_ready  out  1  request accepted this edge when also start_valid.
REQ-008 op  in  2  00 MUL (low WIDTH bits), 01 DIV (quotient), 10 REM (remainder), 11 reserved.
REQ-009 is_signed  in  1  signed-operation request (see Configuration).
REQ-010 a, b  in  WIDTH each  dividend/multiplicand, divisor/multiplier.
REQ-011 tag_in  in  TAG_W  tag carried with the request.
REQ-012 flush  in  1  abort in-flight operation (pipeline redirect).
REQ-013 res_valid  out  1  result available.
REQ-014 res_ready  in  1  consumer takes result this edge when also res_valid.
REQ-015 result  out  WIDTH  operation result.
REQ-016 tag_out  out  TAG_W  tag of the result.
REQ-017 div_by_zero  out  1  result came from DIV/REM with b==0.

Function
REQ-018 States IDLE, RUN, DONE; res_valid SHALL be 1 exactly in DONE.
REQ-019 start_ready SHALL be 1 in IDLE, and in DONE while res_ready=1, and 0 whenever flush=1.
REQ-020 On acceptance, a, b, op, is_signed and tag_in SHALL be latched; later input changes SHALL have no effect.
REQ-021 MUL SHALL be radix-2 shift-add, DIV/REM radix-2 restoring, one bit per cycle, one iteration counter of ceil(log2(WIDTH+1)) bits.
REQ-022 MUL/DIV/REM with nonzero divisor SHALL remain in RUN for exactly WIDTH edges; res_valid SHALL rise WIDTH+1 edges after the acceptance edge; no data-dependent early exit.
REQ-023 DIV/REM with b==0 SHALL go directly to DONE on the next edge: DIV result 0, REM result a, div_by_zero=1.
REQ-024 op 11 SHALL go directly to DONE with result 0, div_by_zero 0.
REQ-025 result, tag_out and div_by_zero SHALL be stable throughout DONE until the handshake.
REQ-026 DONE with res_ready=1 and no new start SHALL go to IDLE; with a simultaneous accepted start it SHALL go to RUN (or DONE per REQ-023/024) with no bubble.
REQ-027 flush=1 SHALL force IDLE on the next edge from any state, discarding work; flush SHALL win over start_valid and res_ready in the same cycle.
REQ-028 MUL overflow beyond WIDTH bits SHALL be discarded (wrap-around).

Reset
REQ-029 Reset SHALL immediately force IDLE, counter 0, result 0, tag_out 0, div_by_zero 0, res_valid 0; start_ready SHALL read 1 after reset deasserts.
REQ-030 Reset mid-RUN SHALL discard the operation with no result produced.

Configuration
REQ-031 Macro TINKER_MULDIV_SIGNED_EN defined: is_signed=1 SHALL compute on magnitudes and fix signs after the computation; quotient sign = a^b, remainder sign = sign of a, product two's-complement low bits; DIV of MIN by -1 SHALL give MIN, REM 0; latency unchanged.
REQ-032 Macro undefined: is_signed SHALL be ignored (treated 0); the port SHALL remain present.

Verification (WIDTH=64, TAG_W=5)
REQ-033 Reset, accept MUL a=7 b=6 tag=3 -> res_valid after exactly 65 edges, result 42, tag_out 3, div_by_zero 0.
REQ-034 DIV a=100 b=7 then REM same operands back-to-back under constant res_ready=1 -> 14 then 2, no idle cycle between.
REQ-035 DIV a=5 b=0 -> res_valid one edge after acceptance, result 0, div_by_zero 1; REM a=5 b=0 -> result 5.
REQ-036 flush pulsed at RUN cycle 30 with start_valid high -> IDLE next edge, no res_valid, start_ready 1 the cycle after.
REQ-037 res_ready held 0 for 10 cycles in DONE -> result/tag stable, start_ready 0; reset asserted mid-RUN -> all outputs 0 immediately.
REQ-038 With TINKER_MULDIV_SIGNED_EN: DIV -7/2 -> -3, REM -7/2 -> -1, DIV 0x8000000000000000/-1 -> 0x8000000000000000; without it, is_signed=1 DIV 0xFFFFFFFFFFFFFFF9/2 -> 0x7FFFFFFFFFFFFFFC.

Source files
------------

// File: rtl/tinker_muldiv.sv
// tinker_muldiv: iterative radix-2 shift-add multiplier / restoring divider with tagged results.
// Latency: result valid WIDTH+1 edges after acceptance (acceptance edge counted); div-by-zero and reserved op finish on the acceptance edge.
// Backpressure: result is held in DONE until res_ready; a new request is accepted on the same edge the result drains.
// Optional feature: define TINKER_MULDIV_SIGNED_EN to honour is_signed (magnitude compute, sign fix-up at the end).
module tinker_muldiv #(
  parameter int WIDTH = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [1:0]       op,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] tag_out,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MUL = 2'b00;
  localparam logic [1:0] OP_DIV = 2'b01;
  localparam logic [1:0] OP_REM = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       op_q;
  logic             neg_q;
  // x_q: multiplicand (shifts left) or divisor; y_q: multiplier (shifts right) or dividend/quotient
  logic [WIDTH-1:0] x_q, y_q, acc_q;

  logic             accept, signed_req, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] mul_acc, div_acc, div_y, raw_fin, fin;
  logic [WIDTH:0]   rem_sh, diff;

`ifdef TINKER_MULDIV_SIGNED_EN
  assign signed_req = is_signed;
`else
  logic unused_is_signed;
  assign unused_is_signed = is_signed;
  assign signed_req = 1'b0;
`endif

  assign start_ready = !reset && !flush &&
                       ((state == S_IDLE) || ((state == S_DONE) && res_ready));
  assign res_valid   = (state == S_DONE);
  assign accept      = start_valid && start_ready;

  assign a_neg  = signed_req & a[WIDTH-1];
  assign b_neg  = signed_req & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;
  assign b_zero = (b == '0);

  // One iteration step on the held operands, plus the sign-corrected final value
  always_comb begin
    mul_acc = y_q[0] ? (acc_q + x_q) : acc_q;
    rem_sh  = {acc_q, y_q[WIDTH-1]};
    diff    = rem_sh - {1'b0, x_q};
    div_acc = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    div_y   = {y_q[WIDTH-2:0], ~diff[WIDTH]};
    case (op_q)
      OP_MUL:  raw_fin = mul_acc;
      OP_DIV:  raw_fin = div_y;
      default: raw_fin = div_acc;
    endcase
    fin = neg_q ? -raw_fin : raw_fin;
  end

  // Control FSM and datapath registers; flush beats any start or drain in the same cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      cnt         <= '0;
      op_q        <= OP_MUL;
      neg_q       <= 1'b0;
      x_q         <= '0;
      y_q         <= '0;
      acc_q       <= '0;
      result      <= '0;
      tag_out     <= '0;
      div_by_zero <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else if (accept) begin
      // accept only happens from IDLE or from a draining DONE, so this also covers back-to-back
      tag_out <= tag_in;
      op_q    <= op;
      neg_q   <= (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
      cnt     <= '0;
      acc_q   <= '0;
      if (op == OP_MUL) begin
        x_q <= a_mag;
        y_q <= b_mag;
      end else begin
        x_q <= b_mag;
        y_q <= a_mag;
      end
      if (op == OP_RSV) begin
        state       <= S_DONE;
        result      <= '0;
        div_by_zero <= 1'b0;
      end else if ((op != OP_MUL) && b_zero) begin
        state       <= S_DONE;
        result      <= (op == OP_DIV) ? '0 : a;
        div_by_zero <= 1'b1;
      end else begin
        state <= S_RUN;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (op_q == OP_MUL) begin
            acc_q <= mul_acc;
            x_q   <= x_q << 1;
            y_q   <= y_q >> 1;
          end else begin
            acc_q <= div_acc;
            y_q   <= div_y;
          end
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state       <= S_DONE;
            result      <= fin;
            div_by_zero <= 1'b0;
            cnt         <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DONE: if (res_ready) state <= S_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tinker_muldiv.sv
// tb_tinker_muldiv: directed scoreboard bench for tinker_muldiv (WIDTH=64, TAG_W=5).
// Stimulus pushes expected results when a request is accepted; a monitor pops on each result handshake.
// Latency, flush, backpressure and reset behaviour are checked inline by the stimulus process.
module tb_tinker_muldiv;

  localparam int W = 64;
  localparam int T = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_valid, start_ready;
  logic [1:0]   op;
  logic         is_signed;
  logic [W-1:0] a, b;
  logic [T-1:0] tag_in;
  logic         flush;
  logic         res_valid, res_ready;
  logic [W-1:0] result;
  logic [T-1:0] tag_out;
  logic         div_by_zero;

  always #5 clk = ~clk;

  tinker_muldiv #(.WIDTH(W), .TAG_W(T)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .op(op), .is_signed(is_signed), .a(a), .b(b), .tag_in(tag_in),
    .flush(flush),
    .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .tag_out(tag_out), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor: compare every consumed result against the oldest expectation
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (res_valid && res_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_result actual=%h tag=%0d required=none", result, tag_out);
        end else begin
          e = sb.pop_front();
          chk("sb_result", result, e.res);
          chk("sb_tag", W'(tag_out), W'(e.tag));
          chk("sb_dbz", W'(div_by_zero), W'(e.dbz));
        end
      end
    end
  end

  // Present a request until accepted; optionally queue its expected response
  task automatic send(input logic [1:0] o, input logic s, input logic [W-1:0] av,
                      input logic [W-1:0] bv, input logic [T-1:0] t, input logic push,
                      input logic [W-1:0] er, input logic ez, output logic in_done);
    int   n;
    exp_t e;
    start_valid = 1'b1; op = o; is_signed = s; a = av; b = bv; tag_in = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!start_ready && n < 300);
    if (!start_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no_accept required=accept tag=%0d", t);
    end
    in_done = res_valid;
    @(posedge clk);
    if (push) begin
      e.res = er; e.tag = t; e.dbz = ez;
      sb.push_back(e);
    end
    #2;
    start_valid = 1'b0; op = 2'b11; is_signed = ~s;
    a = 64'hDEAD_BEEF_0BAD_F00D; b = '1; tag_in = ~t;
  endtask

  // Count edges from acceptance (counted as 1) until res_valid is seen
  task automatic lat(input string name, input int exp_n);
    int n;
    n = 1;
    @(negedge clk);
    while (!res_valid && n < 300) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk(name, W'(n), W'(exp_n));
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic d;
    int   seen;
    int   n;
    reset = 1'b1; start_valid = 1'b0; op = 2'b00; is_signed = 1'b0;
    a = '0; b = '0; tag_in = '0; flush = 1'b0; res_ready = 1'b1;

    #12;
    chk("rst_res_valid", W'(res_valid), 0);
    chk("rst_start_ready", W'(start_ready), 0);
    chk("rst_result", result, 0);
    chk("rst_tag", W'(tag_out), 0);
    chk("rst_dbz", W'(div_by_zero), 0);
    @(posedge clk); #2; reset = 1'b0;
    @(negedge clk);
    chk("post_rst_start_ready", W'(start_ready), 1);
    chk("post_rst_res_valid", W'(res_valid), 0);
    step();

    // basic multiply and latency
    send(2'b00, 1'b0, 64'd7, 64'd6, 5'd3, 1'b1, 64'd42, 1'b0, d);
    lat("mul_latency", 65);
    step();

    // DIV then REM with no bubble
    send(2'b01, 1'b0, 64'd100, 64'd7, 5'd4, 1'b1, 64'd14, 1'b0, d);
    send(2'b10, 1'b0, 64'd100, 64'd7, 5'd5, 1'b1, 64'd2, 1'b0, d);
    chk("no_bubble_accept_in_done", W'(d), 1);
    lat("rem_latency", 65);
    step();

    // divide by zero and reserved op complete immediately
    send(2'b01, 1'b0, 64'd5, 64'd0, 5'd6, 1'b1, 64'd0, 1'b1, d);
    lat("div0_latency", 1);
    step();
    send(2'b10, 1'b0, 64'd5, 64'd0, 5'd7, 1'b1, 64'd5, 1'b1, d);
    lat("rem0_latency", 1);
    step();
    send(2'b11, 1'b0, 64'd9, 64'd9, 5'd8, 1'b1, 64'd0, 1'b0, d);
    lat("rsv_latency", 1);
    step();

    // multiply wrap-around and a wide divide
    send(2'b00, 1'b0, '1, 64'd3, 5'd10, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, d);
    lat("wrap_latency", 65);
    step();
    send(2'b01, 1'b0, '1, 64'h1_0000_0000, 5'd11, 1'b1, 64'hFFFF_FFFF, 1'b0, d);
    send(2'b10, 1'b0, '1, 64'h1_0000_0000, 5'd12, 1'b1, 64'hFFFF_FFFF, 1'b0, d);
    lat("wide_rem_latency", 65);
    step();

    // flush at RUN cycle 30 with a competing start
    send(2'b00, 1'b0, 64'd7, 64'd6, 5'd13, 1'b0, '0, 1'b0, d);
    repeat (29) step();
    flush = 1'b1; start_valid = 1'b1; op = 2'b00; a = 64'd1; b = 64'd1; tag_in = 5'd14;
    @(negedge clk);
    chk("flush_blocks_start", W'(start_ready), 0);
    @(posedge clk); #2;
    flush = 1'b0; start_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_valid", W'(res_valid), 0);
    chk("flush_start_ready", W'(start_ready), 1);
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("flush_no_result", W'(seen), 0);
    step();

    // backpressure: result held for 10 cycles
    res_ready = 1'b0;
    send(2'b00, 1'b0, 64'd16, 64'd16, 5'd9, 1'b1, 64'd256, 1'b0, d);
    lat("bp_latency", 65);
    for (int i = 0; i < 10; i++) begin
      chk("bp_result", result, 64'd256);
      chk("bp_tag", W'(tag_out), 64'd9);
      chk("bp_start_ready", W'(start_ready), 0);
      chk("bp_res_valid", W'(res_valid), 1);
      @(posedge clk);
      @(negedge clk);
    end
    @(posedge clk); #2;
    res_ready = 1'b1;
    step();

    // reset in the middle of RUN
    send(2'b00, 1'b0, 64'd3, 64'd3, 5'd14, 1'b0, '0, 1'b0, d);
    repeat (20) step();
    #1 reset = 1'b1;
    #1;
    chk("midrst_res_valid", W'(res_valid), 0);
    chk("midrst_start_ready", W'(start_ready), 0);
    chk("midrst_result", result, 0);
    chk("midrst_tag", W'(tag_out), 0);
    chk("midrst_dbz", W'(div_by_zero), 0);
    @(posedge clk); #2; reset = 1'b0;
    seen = 0;
    repeat (80) begin
      @(negedge clk);
      if (res_valid) seen++;
    end
    chk("midrst_no_result", W'(seen), 0);
    chk("midrst_start_ready_after", W'(start_ready), 1);
    step();

`ifdef TINKER_MULDIV_SIGNED_EN
    send(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, d);
    lat("sdiv_latency", 65);
    step();
    send(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd16, 1'b1, '1, 1'b0, d);
    lat("srem_latency", 65);
    step();
    send(2'b01, 1'b1, 64'h8000_0000_0000_0000, '1, 5'd17, 1'b1, 64'h8000_0000_0000_0000, 1'b0, d);
    lat("sdiv_min_latency", 65);
    step();
    send(2'b10, 1'b1, 64'h8000_0000_0000_0000, '1, 5'd18, 1'b1, 64'd0, 1'b0, d);
    lat("srem_min_latency", 65);
    step();
    send(2'b00, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 5'd19, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, d);
    lat("smul_latency", 65);
    step();
    send(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd20, 1'b1, 64'h7FFF_FFFF_FFFF_FFFC, 1'b0, d);
    lat("udiv_latency", 65);
    step();
`else
    send(2'b01, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd15, 1'b1, 64'h7FFF_FFFF_FFFF_FFFC, 1'b0, d);
    lat("ignsign_div_latency", 65);
    step();
    send(2'b10, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd16, 1'b1, 64'd1, 1'b0, d);
    lat("ignsign_rem_latency", 65);
    step();
`endif

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", W'(sb.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
